// File: rtl/pll_phase_sequencer.sv
// PLL dynamic phase-shift sequencer: drives PHASESEL/PHASEDIR/PHASESTEP, then waits for relock.
// Define PLL_PHASE_TRACK_EN to build per-output signed step-offset tracking on phase_ofs.
module pll_phase_sequencer #(
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned PULSE_CYC    = 4,
    parameter int unsigned GAP_CYC      = 8,
    parameter int unsigned LOCK_TIMEOUT = 1023
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [3:0] req_count,
    output logic [1:0] phasesel,
    output logic       phasedir,
    output logic       phasestep,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [1:0] rd_sel,
    output logic [7:0] phase_ofs
);
    localparam int unsigned TMR_W = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OFS_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_LOCKWAIT
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       sel_q, sel_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept_c;
    logic             pulse_done_c;
    logic             lock_lost_c;

    // Ready is gated by the pulse flags so a done/err cycle never overlaps a new accept.
    assign req_ready = ~reset & (state_q == ST_IDLE) & pll_locked & ~done_q & ~err_q;
    assign accept_c  = req_valid & req_ready;
    assign lock_lost_c = ~pll_locked & (state_q inside {ST_SETUP, ST_PULSE, ST_GAP});

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        rem_d        = rem_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        step_d       = step_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        pulse_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                step_d = 1'b1;
                if (accept_c) begin
                    sel_d = req_sel;
                    dir_d = req_dir;
                    rem_d = req_count;
                    if (req_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        tmr_d   = TMR_W'(SETUP_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = ST_PULSE;
                    step_d  = 1'b0;
                    tmr_d   = TMR_W'(PULSE_CYC - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_q == '0) begin
                    pulse_done_c = 1'b1;
                    state_d      = ST_GAP;
                    step_d       = 1'b1;
                    rem_d        = rem_q - 1'b1;
                    tmr_d        = TMR_W'(GAP_CYC - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (rem_q == '0) begin
                    state_d = ST_LOCKWAIT;
                    tmr_d   = TMR_W'(LOCK_TIMEOUT - 1);
                end else begin
                    state_d = ST_PULSE;
                    step_d  = 1'b0;
                    tmr_d   = TMR_W'(PULSE_CYC - 1);
                end
            end
            ST_LOCKWAIT: begin
                if (pll_locked) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    tmr_d   = '0;
                end else if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = 1'b1;
            end
        endcase
        // Lock loss mid-sequence abandons the remaining steps; a pulse finishing this edge still counts.
        if (lock_lost_c) begin
            state_d = ST_IDLE;
            step_d  = 1'b1;
            rem_d   = '0;
            tmr_d   = '0;
            err_d   = 1'b1;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign phasesel  = sel_q;
    assign phasedir  = dir_q;
    assign phasestep = step_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef PLL_PHASE_TRACK_EN
    localparam logic [OFS_W-1:0] OFS_MAX = 8'h7F;
    localparam logic [OFS_W-1:0] OFS_MIN = 8'h80;

    logic [3:0][OFS_W-1:0] ofs_q;
    logic [OFS_W-1:0]      phase_ofs_q;

    // Saturating per-output offset, advanced once per completed low pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ofs_q       <= '0;
            phase_ofs_q <= '0;
        end else begin
            if (pulse_done_c) begin
                if (dir_q && (ofs_q[sel_q] != OFS_MAX)) begin
                    ofs_q[sel_q] <= ofs_q[sel_q] + 8'd1;
                end else if (!dir_q && (ofs_q[sel_q] != OFS_MIN)) begin
                    ofs_q[sel_q] <= ofs_q[sel_q] - 8'd1;
                end
            end
            phase_ofs_q <= ofs_q[rd_sel];
        end
    end

    assign phase_ofs = phase_ofs_q;
`else
    logic unused_track;
    assign unused_track = ^{rd_sel, pulse_done_c};
    assign phase_ofs    = '0;
`endif

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Self-checking bench for pll_phase_sequencer: request table plus lock-loss, timeout, saturation and reset sequences.
module tb_pll_phase_sequencer;
    localparam int SETUP_CYC    = 4;
    localparam int PULSE_CYC    = 4;
    localparam int GAP_CYC      = 8;
    localparam int LOCK_TIMEOUT = 1023;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [3:0] req_count;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] rd_sel;
    logic [7:0] phase_ofs;

    pll_phase_sequencer #(
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
        .GAP_CYC(GAP_CYC), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_dir(req_dir), .req_count(req_count), .phasesel(phasesel),
        .phasedir(phasedir), .phasestep(phasestep), .busy(busy), .done(done),
        .err(err), .rd_sel(rd_sel), .phase_ofs(phase_ofs)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] sel;
        logic       dir;
        int         pulses;
        int         completed;
        logic       is_err;
    } exp_t;

    typedef struct {
        int sel;
        int dir;
        int count;
        int exp_pulses;
    } vec_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   n_events = 0;
    int   evt_cyc = 0;
    int   first_fall_cyc = 0;
    int   accept_cyc = 0;
    int   mon_pulses = 0;
    int   low_run = 0;
    int   high_run = 0;
    logic prev_step = 1'b1;
    bit   len_chk = 1'b1;
    int   ofs_model [4];
    exp_t mon_e;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: condition not met", name);
    endtask

    function automatic int sat_step(input int v, input logic d);
        if (d) return (v < 127) ? v + 1 : 127;
        return (v > -128) ? v - 1 : -128;
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    always @(posedge clock) cyc++;

    // Monitor: pulse/gap widths, select stability, and completion events popped from the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            mon_pulses = 0; low_run = 0; high_run = 0; prev_step = 1'b1;
        end else begin
            if (!phasestep && prev_step) begin
                if (sb.size() == 0) fail_now("unexpected_pulse");
                else begin
                    check("sel_stable", phasesel, sb[0].sel);
                    check("dir_stable", phasedir, sb[0].dir);
                end
                if (mon_pulses > 0 && len_chk) check("gap_len", high_run, GAP_CYC);
                if (mon_pulses == 0) first_fall_cyc = cyc;
                mon_pulses++;
                low_run = 1;
            end else if (!phasestep) begin
                low_run++;
            end else if (!prev_step) begin
                if (len_chk) check("pulse_len", low_run, PULSE_CYC);
                high_run = 1;
            end else begin
                high_run++;
            end
            prev_step = phasestep;
            if (done || err) begin
                check("done_err_excl", done && err, 0);
                if (sb.size() == 0) fail_now("unexpected_completion");
                else begin
                    mon_e = sb.pop_front();
                    check("completion_is_err", err, mon_e.is_err);
                    check("pulse_count", mon_pulses, mon_e.pulses);
                    for (int k = 0; k < mon_e.completed; k++)
                        ofs_model[mon_e.sel] = sat_step(ofs_model[mon_e.sel], mon_e.dir);
                end
                mon_pulses = 0;
                evt_cyc = cyc;
                n_events++;
            end
        end
    end

    task automatic start_req(input int sel, dir, count, pulses, completed, is_err);
        exp_t e;
        int   k;
        k = 0;
        while (!req_ready && k < 2000) begin tick(); k++; end
        if (!req_ready) fail_now("ready_timeout");
        e.sel = 2'(sel); e.dir = 1'(dir); e.pulses = pulses;
        e.completed = completed; e.is_err = 1'(is_err);
        sb.push_back(e);
        req_sel = 2'(sel); req_dir = 1'(dir); req_count = 4'(count); req_valid = 1'b1;
        tick();
        accept_cyc = cyc;
        req_valid = 1'b0;
        check("accept_sel", phasesel, sel);
        check("accept_dir", phasedir, dir);
        if (count == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_ready_low", req_ready, 0);
        end else begin
            check("busy_set", busy, 1);
            check("no_early_done", done, 0);
        end
    endtask

    task automatic wait_evt(input int target, input int bound);
        int k;
        k = 0;
        while (n_events < target && k < bound) begin tick(); k++; end
        if (n_events < target) fail_now("completion_timeout");
    endtask

    task automatic do_req(input int sel, dir, count);
        int target;
        target = n_events + 1;
        start_req(sel, dir, count, count, count, 0);
        if (count == 0) begin
            tick();
            check("zero_done_one_cycle", done, 0);
            check("zero_busy_after", busy, 0);
        end else begin
            // Requests presented while busy must be dropped.
            req_valid = 1'b1; req_sel = 2'(sel) ^ 2'b11; req_dir = ~1'(dir); req_count = 4'hF;
            repeat (3) tick();
            req_valid = 1'b0;
            check("sel_ignores_busy_req", phasesel, sel);
        end
        wait_evt(target, count * (PULSE_CYC + GAP_CYC) + SETUP_CYC + 50);
        if (count > 0) check("setup_latency", first_fall_cyc - accept_cyc, SETUP_CYC);
    endtask

    task automatic read_ofs(input int s);
        int exp;
        rd_sel = 2'(s);
        tick(); tick();
`ifdef PLL_PHASE_TRACK_EN
        exp = ofs_model[s];
`else
        exp = 0;
`endif
        check("phase_ofs", longint'($signed(phase_ofs)), exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phasesel"}, phasesel, 0);
        check({tag, "_phasedir"}, phasedir, 1);
        check({tag, "_phasestep"}, phasestep, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_ofs"}, phase_ofs, 0);
    endtask

    initial begin
        vec_t vecs [6];
        int   k;
        int   target;
        int   drop_cyc;
        vecs[0] = '{2, 1, 3, 3};
        vecs[1] = '{0, 0, 0, 0};
        vecs[2] = '{1, 0, 1, 1};
        vecs[3] = '{3, 1, 2, 2};
        vecs[4] = '{1, 1, 15, 15};
        vecs[5] = '{2, 0, 4, 4};
        for (int i = 0; i < 4; i++) ofs_model[i] = 0;

        reset = 1'b1; pll_locked = 1'b1; req_valid = 1'b0;
        req_sel = '0; req_dir = 1'b0; req_count = '0; rd_sel = '0;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        check("ready_after_reset", req_ready, 1);

        // Table-driven requests with lock held high.
        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].sel, vecs[i].dir, vecs[i].count);
            if (vecs[i].count > 0) check("vec_first_pulse_seen", first_fall_cyc > accept_cyc, 1);
            if (i == 0) read_ofs(2);
        end
        for (int s = 0; s < 4; s++) read_ofs(s);

        // Lock lost during the second pulse of a five-step request.
        len_chk = 1'b0;
        target = n_events + 1;
        start_req(3, 1, 5, 2, 1, 1);
        k = 0;
        while (!(mon_pulses == 2 && !phasestep) && k < 200) begin tick(); k++; end
        if (k >= 200) fail_now("second_pulse_timeout");
        pll_locked = 1'b0;
        tick();
        check("abort_step_high", phasestep, 1);
        check("abort_err", err, 1);
        check("abort_done_low", done, 0);
        check("abort_busy", busy, 0);
        check("abort_event", n_events, target);
        pll_locked = 1'b1;
        repeat (40) tick();
        check("abort_no_more_pulses", mon_pulses, 0);
        check("abort_no_more_events", n_events, target);
        len_chk = 1'b1;
        read_ofs(3);

        // Lock lost once the gap ends: timeout error, then no ready until relock.
        target = n_events + 1;
        start_req(0, 0, 1, 1, 1, 1);
        k = 0;
        while (!(mon_pulses == 1 && phasestep) && k < 200) begin tick(); k++; end
        if (k >= 200) fail_now("pulse_end_timeout");
        repeat (GAP_CYC) tick();
        pll_locked = 1'b0;
        drop_cyc = cyc;
        wait_evt(target, LOCK_TIMEOUT + 50);
        check("timeout_latency", evt_cyc - drop_cyc, LOCK_TIMEOUT);
        repeat (20) tick();
        check("timeout_ready_low", req_ready, 0);
        check("timeout_idle", busy, 0);
        pll_locked = 1'b1;
        tick();
        check("relock_ready", req_ready, 1);
        read_ofs(0);

        // Single up-steps on output 0 until saturation, then one down-step.
        for (int i = 0; i < 130; i++) do_req(0, 1, 1);
        read_ofs(0);
        do_req(0, 0, 1);
        read_ofs(0);

        // Asynchronous reset while phasestep is low.
        len_chk = 1'b0;
        start_req(2, 1, 3, 3, 0, 0);
        k = 0;
        while (phasestep && k < 100) begin tick(); k++; end
        check("pre_reset_step_low", phasestep, 0);
        #1 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        tick(); tick();
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) ofs_model[i] = 0;
        repeat (30) tick();
        check("post_reset_no_pulses", mon_pulses, 0);
        check("post_reset_step", phasestep, 1);
        check("post_reset_busy", busy, 0);
        len_chk = 1'b1;
        read_ofs(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
